// File: rtl/exec_mem_model.sv
// rtl/exec_mem_model.sv - stateful EXEC memory model with deterministic fill, read latency pipe and access counters
module exec_mem_model #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int INIT_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  init_done,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic                  rw_collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Reject unsupported configurations at elaboration time.
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("exec_mem_model: RD_LATENCY must be in 1..4");
  end
  if (INIT_MODE < 0 || INIT_MODE > 2) begin : g_bad_init_mode
    $error("exec_mem_model: INIT_MODE must be 0, 1 or 2");
  end

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] fill_ptr;
  logic [ADDR_WIDTH-1:0] fill_ptr_inv;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  fill_en;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

  // State register: reset always restarts the array fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave INIT once the last address has been written.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (fill_ptr == '1) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  // State outputs: requests are only honoured once the fill is complete.
  always_comb begin
    fill_en   = (state == ST_INIT);
    init_done = (state == ST_READY);
    rd_accept = (state == ST_READY) && exec_rd_req;
    wr_accept = (state == ST_READY) && exec_wr_req;
  end

  // Fill pointer walks the whole array once per reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_ptr <= '0;
    end else if (fill_en) begin
      fill_ptr <= fill_ptr + ADDR_WIDTH'(1);
    end
  end

  // Fill pattern; the address is zero-extended or truncated to the word width.
  always_comb begin
    fill_ptr_inv = ~fill_ptr;
    case (INIT_MODE)
      1:       fill_word = DATA_WIDTH'(fill_ptr);
      2:       fill_word = DATA_WIDTH'(fill_ptr_inv);
      default: fill_word = '0;
    endcase
  end

  // Backing array: fill writes during INIT, EXEC writes once READY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_en) begin
        mem[fill_ptr] <= fill_word;
      end else if (wr_accept) begin
        mem[exec_wr_addr] <= exec_wr_data;
      end
    end
  end

  // Read pipe: stage 0 samples the array before any same-edge write lands;
  // data only advances with its valid bit so the last stage holds its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data[0] <= mem[exec_rd_addr];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign exec_rd_valid = pipe_vld[RD_LATENCY-1];
  assign exec_rd_data  = pipe_data[RD_LATENCY-1];

  // Saturating access counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_accept && rd_count != 16'hFFFF) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wr_accept && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Collision flag covers exactly the cycle after a same-address read and write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_collision <= 1'b0;
    end else begin
      rw_collision <= rd_accept && wr_accept && (exec_rd_addr == exec_wr_addr);
    end
  end

endmodule
